// File: rtl/fifo_ptr_ctrl_if.sv
// Handshake and status bundle between the DMA FIFO pointer controller and its write/read clients.
// master drives strobes and mode; slave (the controller) returns acks, lane enables, pointers and flags.
interface fifo_ptr_ctrl_if;
    logic       flush;
    logic       byte_mode;
    logic       wr_stb;
    logic       commit;
    logic       rd_stb;
    logic       wr_ack;
    logic       rd_ack;
    logic [3:0] lane_we;
    logic [2:0] wr_ptr;
    logic [2:0] rd_ptr;
    logic [1:0] byte_ptr;
    logic [3:0] level;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic       partial;
    logic       ovf;
    logic       udf;

    modport master (
        output flush, byte_mode, wr_stb, commit, rd_stb,
        input  wr_ack, rd_ack, lane_we, wr_ptr, rd_ptr, byte_ptr, level,
               full, empty, almost_full, almost_empty, partial, ovf, udf
    );

    modport slave (
        input  flush, byte_mode, wr_stb, commit, rd_stb,
        output wr_ack, rd_ack, lane_we, wr_ptr, rd_ptr, byte_ptr, level,
               full, empty, almost_full, almost_empty, partial, ovf, udf
    );
endinterface

// File: rtl/fifo_ptr_ctrl.sv
// Pointer/level/flag controller for an 8x32 DMA FIFO with byte packing on the write side.
// Acks and lane enables are same-cycle combinational; state and flags update next cycle; full/empty reject strobes.
module fifo_ptr_ctrl #(
    parameter logic [3:0] AF_LVL = 4'd6,
    parameter logic [3:0] AE_LVL = 4'd1
) (
    input  logic          clk,
    input  logic          rst,
    fifo_ptr_ctrl_if.slave bus
);
    logic [2:0] wr_ptr_q, rd_ptr_q;
    logic [1:0] byte_ptr_q;
    logic [3:0] level_q;
    logic       full_q, empty_q, af_q, ae_q, partial_q, ovf_q, udf_q;

    logic       clr, ebm, wr_ok, rd_ok, push;
    logic [3:0] lane_we;
    logic [3:0] level_nxt;
    logic [1:0] byte_ptr_nxt;

    always_comb begin
        clr   = rst | bus.flush;
        // A started longword must finish packed even if byte_mode drops.
        ebm   = bus.byte_mode | (byte_ptr_q != 2'd0);
        wr_ok = bus.wr_stb & ~full_q & ~clr;
        rd_ok = bus.rd_stb & ~empty_q & ~clr;

        lane_we = 4'b0000;
        if (wr_ok)
            lane_we = ebm ? (4'b1000 >> byte_ptr_q) : 4'b1111;

        push = (wr_ok & (~ebm | (byte_ptr_q == 2'd3) | bus.commit))
             | (~clr & bus.commit & (byte_ptr_q != 2'd0) & ~bus.wr_stb);

        level_nxt = level_q + {3'b000, push} - {3'b000, rd_ok};

        byte_ptr_nxt = byte_ptr_q;
        if (push)
            byte_ptr_nxt = 2'd0;
        else if (wr_ok & ebm)
            byte_ptr_nxt = byte_ptr_q + 2'd1;
    end

    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            wr_ptr_q   <= 3'd0;
            rd_ptr_q   <= 3'd0;
            byte_ptr_q <= 2'd0;
            level_q    <= 4'd0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            af_q       <= (AF_LVL == 4'd0);
            ae_q       <= 1'b1;
            partial_q  <= 1'b0;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_q + {2'b00, push};
            rd_ptr_q   <= rd_ptr_q + {2'b00, rd_ok};
            byte_ptr_q <= byte_ptr_nxt;
            level_q    <= level_nxt;
            full_q     <= (level_nxt == 4'd8);
            empty_q    <= (level_nxt == 4'd0);
            af_q       <= (level_nxt >= AF_LVL);
            ae_q       <= (level_nxt <= AE_LVL);
            partial_q  <= (byte_ptr_nxt != 2'd0);
            ovf_q      <= ovf_q | (bus.wr_stb & full_q);
            udf_q      <= udf_q | (bus.rd_stb & empty_q);
        end
    end

    assign bus.wr_ack       = wr_ok;
    assign bus.rd_ack       = rd_ok;
    assign bus.lane_we      = lane_we;
    assign bus.wr_ptr       = wr_ptr_q;
    assign bus.rd_ptr       = rd_ptr_q;
    assign bus.byte_ptr     = byte_ptr_q;
    assign bus.level        = level_q;
    assign bus.full         = full_q;
    assign bus.empty        = empty_q;
    assign bus.almost_full  = af_q;
    assign bus.almost_empty = ae_q;
    assign bus.partial      = partial_q;
    assign bus.ovf          = ovf_q;
    assign bus.udf          = udf_q;
endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// Bench for fifo_ptr_ctrl: directed vector table, flush/reset mid-longword sequences, random run against a counting model.
module tb_fifo_ptr_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    fifo_ptr_ctrl_if bus ();

    fifo_ptr_ctrl #(.AF_LVL(4'd6), .AE_LVL(4'd1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        bit         rst, flush, bm, wr, cm, rd;
        bit         wack, rack;
        logic [3:0] we;
        logic [3:0] lvl;
        logic [1:0] bp;
        logic [2:0] wp, rp;
        logic [6:0] flg;
    } vec_t;

    // {full, empty, almost_full, almost_empty, partial, ovf, udf} for AF=6, AE=1
    function automatic logic [6:0] flg(int l, bit p, bit o, bit u);
        return {l == 8, l == 0, l >= 6, l <= 1, p, o, u};
    endfunction

    function automatic vec_t mk(bit r, bit f, bit bm, bit wr, bit cm, bit rd,
                                bit wa, bit ra, logic [3:0] we,
                                int lvl, int bp, int wp, int rp, logic [6:0] fl);
        vec_t v;
        v.rst = r;  v.flush = f; v.bm = bm; v.wr = wr; v.cm = cm; v.rd = rd;
        v.wack = wa; v.rack = ra; v.we = we;
        v.lvl = 4'(lvl); v.bp = 2'(bp); v.wp = 3'(wp); v.rp = 3'(rp); v.flg = fl;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic apply(input vec_t v, input string tag);
        @(negedge clk);
        rst           = v.rst;
        bus.flush     = v.flush;
        bus.byte_mode = v.bm;
        bus.wr_stb    = v.wr;
        bus.commit    = v.cm;
        bus.rd_stb    = v.rd;
        #1;
        chk({tag, " wr_ack"},  {31'b0, bus.wr_ack}, {31'b0, v.wack});
        chk({tag, " rd_ack"},  {31'b0, bus.rd_ack}, {31'b0, v.rack});
        chk({tag, " lane_we"}, {28'b0, bus.lane_we}, {28'b0, v.we});
        @(posedge clk);
        #1;
        chk({tag, " level"},    {28'b0, bus.level},    {28'b0, v.lvl});
        chk({tag, " byte_ptr"}, {30'b0, bus.byte_ptr}, {30'b0, v.bp});
        chk({tag, " wr_ptr"},   {29'b0, bus.wr_ptr},   {29'b0, v.wp});
        chk({tag, " rd_ptr"},   {29'b0, bus.rd_ptr},   {29'b0, v.rp});
        chk({tag, " flags"},
            {25'b0, bus.full, bus.empty, bus.almost_full, bus.almost_empty,
             bus.partial, bus.ovf, bus.udf},
            {25'b0, v.flg});
    endtask

    // Reach LEVEL 5 with two packed bytes pending, then clear while a byte write is requested.
    task automatic clear_mid_longword(input bit use_rst);
        apply(mk(0,1,0,0,0,0, 0,0,4'h0, 0,0,0,0, flg(0,0,0,0)), "pre_flush");
        for (int k = 1; k <= 5; k++)
            apply(mk(0,0,0,1,0,0, 1,0,4'hF, k,0,k,0, flg(k,0,0,0)), "mid_fill");
        apply(mk(0,0,1,1,0,0, 1,0,4'b1000, 5,1,5,0, flg(5,1,0,0)), "mid_b0");
        apply(mk(0,0,1,1,0,0, 1,0,4'b0100, 5,2,5,0, flg(5,1,0,0)), "mid_b1");
        apply(mk(use_rst,!use_rst,1,1,0,0, 0,0,4'h0, 0,0,0,0, flg(0,0,0,0)),
              use_rst ? "mid_rst" : "mid_flush");
    endtask

    initial begin
        vec_t tbl[$];
        int pushed, popped, bytes, lvl;
        bit ovf_m, udf_m, r, f, bm, wr, cm, rd, wa, ra, ebm, close;
        logic [3:0] we;

        rst = 1'b1;
        bus.flush = 1'b0; bus.byte_mode = 1'b0; bus.wr_stb = 1'b0;
        bus.commit = 1'b0; bus.rd_stb = 1'b0;
        repeat (2) @(posedge clk);

        tbl.push_back(mk(1,0,0,1,0,0, 0,0,4'h0, 0,0,0,0, flg(0,0,0,0)));
        for (int k = 1; k <= 8; k++)
            tbl.push_back(mk(0,0,0,1,0,0, 1,0,4'hF, k,0,k%8,0, flg(k,0,0,0)));
        tbl.push_back(mk(0,0,0,1,0,0, 0,0,4'h0, 8,0,0,0, flg(8,0,1,0)));
        tbl.push_back(mk(0,1,0,0,0,0, 0,0,4'h0, 0,0,0,0, flg(0,0,0,0)));
        tbl.push_back(mk(0,0,0,0,0,1, 0,0,4'h0, 0,0,0,0, flg(0,0,0,1)));
        tbl.push_back(mk(0,1,0,0,0,0, 0,0,4'h0, 0,0,0,0, flg(0,0,0,0)));
        for (int k = 0; k < 4; k++)
            tbl.push_back(mk(0,0,1,1,0,0, 1,0,4'b1000 >> k, (k==3)?1:0, (k+1)%4,
                             (k==3)?1:0, 0, flg((k==3)?1:0, k!=3, 0, 0)));
        tbl.push_back(mk(0,0,1,1,0,0, 1,0,4'b1000, 1,1,1,0, flg(1,1,0,0)));
        tbl.push_back(mk(0,0,1,1,0,0, 1,0,4'b0100, 1,2,1,0, flg(1,1,0,0)));
        tbl.push_back(mk(0,0,1,0,1,0, 0,0,4'h0, 2,0,2,0, flg(2,0,0,0)));
        tbl.push_back(mk(0,0,1,1,1,0, 1,0,4'b1000, 3,0,3,0, flg(3,0,0,0)));
        for (int k = 1; k <= 10; k++)
            tbl.push_back(mk(0,0,0,1,0,1, 1,1,4'hF, 3,0,(3+k)%8,k%8, flg(3,0,0,0)));
        tbl.push_back(mk(0,0,0,0,1,0, 0,0,4'h0, 3,0,5,2, flg(3,0,0,0)));
        for (int k = 1; k <= 5; k++)
            tbl.push_back(mk(0,0,0,1,0,0, 1,0,4'hF, 3+k,0,(5+k)%8,2, flg(3+k,0,0,0)));
        tbl.push_back(mk(0,0,0,1,0,1, 0,1,4'h0, 7,0,2,3, flg(7,0,1,0)));
        tbl.push_back(mk(0,0,0,1,0,1, 1,1,4'hF, 7,0,3,4, flg(7,0,1,0)));

        foreach (tbl[i])
            apply(tbl[i], $sformatf("vec%0d", i));

        clear_mid_longword(1'b0);
        clear_mid_longword(1'b1);

        pushed = 0; popped = 0; bytes = 0; ovf_m = 0; udf_m = 0;
        for (int n = 0; n < 3000; n++) begin
            r  = ($urandom_range(0, 199) == 0);
            f  = ($urandom_range(0, 99) == 0);
            bm = $urandom_range(0, 1) == 1;
            wr = $urandom_range(0, 99) < 60;
            cm = $urandom_range(0, 99) < 15;
            rd = $urandom_range(0, 99) < 45;

            lvl = pushed - popped;
            wa  = wr && lvl != 8 && !r && !f;
            ra  = rd && lvl != 0 && !r && !f;
            ebm = bm || bytes != 0;
            we  = !wa ? 4'h0 : (ebm ? 4'(1 << (3 - bytes)) : 4'hF);
            close = (wa && (!ebm || bytes == 3 || cm)) || (!r && !f && cm && bytes != 0 && !wr);

            if (r || f) begin
                pushed = 0; popped = 0; bytes = 0; ovf_m = 0; udf_m = 0;
            end else begin
                ovf_m = ovf_m | (wr && lvl == 8);
                udf_m = udf_m | (rd && lvl == 0);
                if (wa && ebm) bytes = bytes + 1;
                if (close) begin
                    pushed++;
                    bytes = 0;
                end
                if (ra) popped++;
            end
            lvl = pushed - popped;
            apply(mk(r,f,bm,wr,cm,rd, wa,ra,we, lvl,bytes,pushed%8,popped%8,
                     flg(lvl, bytes != 0, ovf_m, udf_m)), "rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
